// File: rtl/inter_rm_buffer_v2.sv
// AXI4-slave write/read burst buffer between two reconfigurable modules.
// Bursts are admitted only when they can complete without stalling.
module inter_rm_buffer_v2 #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned ADDR_WIDTH = 30,
   parameter int unsigned DEPTH_LOG2 = 9
) (
   input  logic                    clk,
   input  logic                    resetn,
   // write address
   input  logic                    s_axi_inter_rm_awvalid,
   output logic                    s_axi_inter_rm_awready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_inter_rm_awaddr,
   input  logic [7:0]              s_axi_inter_rm_awlen,
   input  logic [2:0]              s_axi_inter_rm_awsize,
   input  logic [1:0]              s_axi_inter_rm_awburst,
   input  logic                    s_axi_inter_rm_awlock,
   input  logic [3:0]              s_axi_inter_rm_awcache,
   input  logic [2:0]              s_axi_inter_rm_awprot,
   input  logic [3:0]              s_axi_inter_rm_awqos,
   input  logic [3:0]              s_axi_inter_rm_awregion,
   // write data
   input  logic                    s_axi_inter_rm_wvalid,
   output logic                    s_axi_inter_rm_wready,
   input  logic [DATA_WIDTH-1:0]   s_axi_inter_rm_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_inter_rm_wstrb,
   input  logic                    s_axi_inter_rm_wlast,
   // write response
   output logic                    s_axi_inter_rm_bvalid,
   input  logic                    s_axi_inter_rm_bready,
   output logic [1:0]              s_axi_inter_rm_bresp,
   // read address
   input  logic                    s_axi_inter_rm_arvalid,
   output logic                    s_axi_inter_rm_arready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_inter_rm_araddr,
   input  logic [7:0]              s_axi_inter_rm_arlen,
   input  logic [2:0]              s_axi_inter_rm_arsize,
   input  logic [1:0]              s_axi_inter_rm_arburst,
   input  logic                    s_axi_inter_rm_arlock,
   input  logic [3:0]              s_axi_inter_rm_arcache,
   input  logic [2:0]              s_axi_inter_rm_arprot,
   input  logic [3:0]              s_axi_inter_rm_arqos,
   input  logic [3:0]              s_axi_inter_rm_arregion,
   // read data
   output logic                    s_axi_inter_rm_rvalid,
   input  logic                    s_axi_inter_rm_rready,
   output logic [DATA_WIDTH-1:0]   s_axi_inter_rm_rdata,
   output logic                    s_axi_inter_rm_rlast,
   output logic [1:0]              s_axi_inter_rm_rresp,
   // status
   output logic [DEPTH_LOG2:0]     fill_level,
   output logic                    fifo_empty,
   output logic                    fifo_full
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic       {RIdle, RData}        r_state_e;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   w_state_e              w_state_q;
   r_state_e              r_state_q;
   logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
   logic [CW-1:0]         count_q;
   logic [7:0]            wcnt_q, rcnt_q;
   logic                  err_q;
   logic                  live_q;

   logic [CW-1:0]         free_space, aw_beats, ar_beats;
   logic                  aw_hs, w_hs, ar_hs, r_hs;

   assign free_space = CW'(DEPTH) - count_q;
   assign aw_beats   = CW'(s_axi_inter_rm_awlen) + CW'(1);
   assign ar_beats   = CW'(s_axi_inter_rm_arlen) + CW'(1);

   // live_q keeps every ready low while reset is held and releases it one cycle later
   assign s_axi_inter_rm_awready = live_q && (w_state_q == WIdle) && (free_space >= aw_beats);
   assign s_axi_inter_rm_wready  = (w_state_q == WData);
   assign s_axi_inter_rm_bvalid  = (w_state_q == WResp);
   assign s_axi_inter_rm_bresp   = (s_axi_inter_rm_bvalid && err_q) ? 2'b10 : 2'b00;
   assign s_axi_inter_rm_arready = live_q && (r_state_q == RIdle) && (count_q >= ar_beats);
   assign s_axi_inter_rm_rvalid  = (r_state_q == RData);
   assign s_axi_inter_rm_rdata   = mem[rptr_q];
   assign s_axi_inter_rm_rlast   = s_axi_inter_rm_rvalid && (rcnt_q == 8'd0);
   assign s_axi_inter_rm_rresp   = 2'b00;

   assign aw_hs = s_axi_inter_rm_awvalid && s_axi_inter_rm_awready;
   assign w_hs  = s_axi_inter_rm_wvalid  && s_axi_inter_rm_wready;
   assign ar_hs = s_axi_inter_rm_arvalid && s_axi_inter_rm_arready;
   assign r_hs  = s_axi_inter_rm_rvalid  && s_axi_inter_rm_rready;

   assign fill_level = count_q;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(DEPTH));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         live_q <= 1'b0;
      end else begin
         live_q <= 1'b1;
      end
   end

   // Write FSM: admission guarantees room, so W_DATA never stalls.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         w_state_q <= WIdle;
         wcnt_q    <= 8'd0;
         err_q     <= 1'b0;
         wptr_q    <= '0;
      end else begin
         unique case (w_state_q)
            WIdle: begin
               if (aw_hs) begin
                  wcnt_q    <= s_axi_inter_rm_awlen;
                  err_q     <= 1'b0;
                  w_state_q <= WData;
               end
            end
            WData: begin
               if (w_hs) begin
                  wptr_q <= wptr_q + DEPTH_LOG2'(1);
                  if (wcnt_q == 8'd0) begin
                     err_q     <= err_q | ~s_axi_inter_rm_wlast;
                     w_state_q <= WResp;
                  end else begin
                     err_q  <= err_q | s_axi_inter_rm_wlast;
                     wcnt_q <= wcnt_q - 8'd1;
                  end
               end
            end
            WResp: begin
               if (s_axi_inter_rm_bready) begin
                  w_state_q <= WIdle;
               end
            end
            default: w_state_q <= WIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state_q <= RIdle;
         rcnt_q    <= 8'd0;
         rptr_q    <= '0;
      end else begin
         unique case (r_state_q)
            RIdle: begin
               if (ar_hs) begin
                  rcnt_q    <= s_axi_inter_rm_arlen;
                  r_state_q <= RData;
               end
            end
            RData: begin
               if (r_hs) begin
                  rptr_q <= rptr_q + DEPTH_LOG2'(1);
                  rcnt_q <= rcnt_q - 8'd1;
                  if (rcnt_q == 8'd0) begin
                     r_state_q <= RIdle;
                  end
               end
            end
            default: r_state_q <= RIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         unique case ({w_hs, r_hs})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (w_hs) begin
         mem[wptr_q] <= s_axi_inter_rm_wdata;
      end
   end

   logic unused_inputs;
   assign unused_inputs = ^{s_axi_inter_rm_awaddr, s_axi_inter_rm_araddr, s_axi_inter_rm_wstrb,
                            s_axi_inter_rm_awsize, s_axi_inter_rm_awburst, s_axi_inter_rm_awlock,
                            s_axi_inter_rm_awcache, s_axi_inter_rm_awprot, s_axi_inter_rm_awqos,
                            s_axi_inter_rm_awregion, s_axi_inter_rm_arsize, s_axi_inter_rm_arburst,
                            s_axi_inter_rm_arlock, s_axi_inter_rm_arcache, s_axi_inter_rm_arprot,
                            s_axi_inter_rm_arqos, s_axi_inter_rm_arregion};

endmodule

// File: tb/tb_inter_rm_buffer_v2.sv
// Bench for inter_rm_buffer_v2: scoreboard of written beats checked against read beats,
// plus a cycle-by-cycle occupancy model.
module tb_inter_rm_buffer_v2;

   localparam int DW     = 32;
   localparam int AW     = 30;
   localparam int DL     = 8;
   localparam int DEPTH  = 256;
   localparam int BUDGET = 4000;

   logic          clk = 1'b0;
   logic          resetn;
   logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic          arvalid, arready, rvalid, rready, rlast;
   logic [AW-1:0] awaddr, araddr;
   logic [7:0]    awlen, arlen;
   logic [DW-1:0] wdata, rdata;
   logic [DW/8-1:0] wstrb;
   logic [1:0]    bresp, rresp;
   logic [2:0]    awsize, arsize, awprot, arprot;
   logic [1:0]    awburst, arburst;
   logic          awlock, arlock;
   logic [3:0]    awcache, arcache, awqos, arqos, awregion, arregion;
   logic [DL:0]   fill_level;
   logic          fifo_empty, fifo_full;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [DW-1:0] sb[$];
   int            fill_model = 0;
   bit            mon_en = 1'b0;

   always #5 clk = ~clk;

   inter_rm_buffer_v2 #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .DEPTH_LOG2(DL)
   ) dut (
      .clk                    (clk),
      .resetn                 (resetn),
      .s_axi_inter_rm_awvalid (awvalid),
      .s_axi_inter_rm_awready (awready),
      .s_axi_inter_rm_awaddr  (awaddr),
      .s_axi_inter_rm_awlen   (awlen),
      .s_axi_inter_rm_awsize  (awsize),
      .s_axi_inter_rm_awburst (awburst),
      .s_axi_inter_rm_awlock  (awlock),
      .s_axi_inter_rm_awcache (awcache),
      .s_axi_inter_rm_awprot  (awprot),
      .s_axi_inter_rm_awqos   (awqos),
      .s_axi_inter_rm_awregion(awregion),
      .s_axi_inter_rm_wvalid  (wvalid),
      .s_axi_inter_rm_wready  (wready),
      .s_axi_inter_rm_wdata   (wdata),
      .s_axi_inter_rm_wstrb   (wstrb),
      .s_axi_inter_rm_wlast   (wlast),
      .s_axi_inter_rm_bvalid  (bvalid),
      .s_axi_inter_rm_bready  (bready),
      .s_axi_inter_rm_bresp   (bresp),
      .s_axi_inter_rm_arvalid (arvalid),
      .s_axi_inter_rm_arready (arready),
      .s_axi_inter_rm_araddr  (araddr),
      .s_axi_inter_rm_arlen   (arlen),
      .s_axi_inter_rm_arsize  (arsize),
      .s_axi_inter_rm_arburst (arburst),
      .s_axi_inter_rm_arlock  (arlock),
      .s_axi_inter_rm_arcache (arcache),
      .s_axi_inter_rm_arprot  (arprot),
      .s_axi_inter_rm_arqos   (arqos),
      .s_axi_inter_rm_arregion(arregion),
      .s_axi_inter_rm_rvalid  (rvalid),
      .s_axi_inter_rm_rready  (rready),
      .s_axi_inter_rm_rdata   (rdata),
      .s_axi_inter_rm_rlast   (rlast),
      .s_axi_inter_rm_rresp   (rresp),
      .fill_level             (fill_level),
      .fifo_empty             (fifo_empty),
      .fifo_full              (fifo_full)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Occupancy model: handshakes seen before an edge take effect after it.
   always @(negedge clk) begin
      if (mon_en) begin
         check_eq("fill_level", 64'(fill_level), 64'(fill_model));
         check_eq("fifo_empty", 64'(fifo_empty), 64'(fill_model == 0));
         check_eq("fifo_full", 64'(fifo_full), 64'(fill_model == DEPTH));
         if (wvalid && wready) fill_model++;
         if (rvalid && rready) fill_model--;
      end
   end

   task automatic write_burst(input int len_m1, input int last_at, input int gap_max,
                              input logic [1:0] exp_resp, input logic [DW-1:0] base);
      int t;
      awlen   = 8'(len_m1);
      awvalid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (awready) break;
         t++;
         if (t > BUDGET) begin
            check_eq("aw_timeout", 0, 1);
            awvalid = 1'b0;
            return;
         end
      end
      step();
      awvalid = 1'b0;
      for (int i = 0; i <= len_m1; i++) begin
         if (gap_max > 0) begin
            wvalid = 1'b0;
            repeat ($urandom_range(0, gap_max)) step();
         end
         wvalid = 1'b1;
         wdata  = base + DW'(i);
         wlast  = (i == last_at);
         t = 0;
         forever begin
            @(negedge clk);
            if (wready) break;
            t++;
            if (t > BUDGET) begin
               check_eq("w_timeout", 0, 1);
               wvalid = 1'b0;
               return;
            end
         end
         sb.push_back(wdata);
         step();
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      bready = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (bvalid) break;
         t++;
         if (t > BUDGET) begin
            check_eq("b_timeout", 0, 1);
            bready = 1'b0;
            return;
         end
      end
      check_eq("bresp", 64'(bresp), 64'(exp_resp));
      check_eq("wready_after_burst", 64'(wready), 0);
      step();
      bready = 1'b0;
   endtask

   task automatic read_burst(input int len_m1, input int gap_max);
      int t;
      logic [DW-1:0] exp;
      arlen   = 8'(len_m1);
      arvalid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (arready) break;
         t++;
         if (t > BUDGET) begin
            check_eq("ar_timeout", 0, 1);
            arvalid = 1'b0;
            return;
         end
      end
      step();
      arvalid = 1'b0;
      check_eq("r_latency", 64'(rvalid), 1);
      for (int i = 0; i <= len_m1; i++) begin
         if (gap_max > 0) begin
            rready = 1'b0;
            repeat ($urandom_range(0, gap_max)) step();
         end
         rready = 1'b1;
         t = 0;
         forever begin
            @(negedge clk);
            if (rvalid) break;
            t++;
            if (t > BUDGET) begin
               check_eq("r_timeout", 0, 1);
               rready = 1'b0;
               return;
            end
         end
         if (sb.size() == 0) begin
            check_eq("sb_underflow", 1, 0);
         end else begin
            exp = sb.pop_front();
            check_eq("rdata", 64'(rdata), 64'(exp));
         end
         check_eq("rlast", 64'(rlast), 64'(i == len_m1));
         step();
      end
      rready = 1'b0;
      check_eq("rvalid_after_burst", 64'(rvalid), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_awready"}, 64'(awready), 0);
      check_eq({tag, "_wready"}, 64'(wready), 0);
      check_eq({tag, "_bvalid"}, 64'(bvalid), 0);
      check_eq({tag, "_bresp"}, 64'(bresp), 0);
      check_eq({tag, "_arready"}, 64'(arready), 0);
      check_eq({tag, "_rvalid"}, 64'(rvalid), 0);
      check_eq({tag, "_fill"}, 64'(fill_level), 0);
      check_eq({tag, "_empty"}, 64'(fifo_empty), 1);
      check_eq({tag, "_full"}, 64'(fifo_full), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int wlens[12];
      int total;
      resetn  = 1'b0;
      awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
      arvalid = 1'b0; rready = 1'b0;
      awaddr = '0; araddr = '0; awlen = '0; arlen = '0; wdata = '0; wstrb = '1;
      awsize = 3'd2; arsize = 3'd2; awburst = 2'b01; arburst = 2'b01;
      awlock = 1'b0; arlock = 1'b0; awcache = '0; arcache = '0;
      awprot = '0; arprot = '0; awqos = '0; arqos = '0; awregion = '0; arregion = '0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      resetn = 1'b1;
      step();
      step();
      mon_en = 1'b1;

      // basic 16-beat round trip
      write_burst(15, 15, 0, 2'b00, 32'h0);
      check_eq("fill_after_w16", 64'(fill_level), 16);
      read_burst(15, 0);
      check_eq("empty_after_r16", 64'(fifo_empty), 1);

      // exact fill, then blocked AW until a beat is read
      write_burst(255, 255, 0, 2'b00, 32'h100);
      check_eq("full_after_256", 64'(fifo_full), 1);
      awlen   = 8'd0;
      awvalid = 1'b1;
      repeat (3) step();
      check_eq("awready_when_full", 64'(awready), 0);
      awvalid = 1'b0;
      read_burst(0, 0);
      check_eq("awready_after_read", 64'(awready), 1);
      read_burst(254, 0);

      // short FIFO blocks AR until enough beats exist
      write_burst(2, 2, 0, 2'b00, 32'h1000);
      arlen = 8'd7;
      repeat (2) step();
      check_eq("arready_short", 64'(arready), 0);
      write_burst(4, 4, 0, 2'b00, 32'h1003);
      check_eq("arready_enough", 64'(arready), 1);
      read_burst(7, 0);

      // early wlast -> SLVERR, still exactly awlen+1 beats; then a clean burst
      write_burst(3, 1, 0, 2'b10, 32'h2000);
      write_burst(3, 3, 0, 2'b00, 32'h3000);
      read_burst(7, 1);

      // concurrent bursts with random gaps, crossing the pointer wrap
      total = 0;
      foreach (wlens[k]) begin
         wlens[k] = int'($urandom_range(1, 40));
         total += wlens[k];
      end
      fork
         begin
            int off;
            off = 0;
            foreach (wlens[k]) begin
               write_burst(wlens[k] - 1, wlens[k] - 1, 3, 2'b00, 32'h4000 + DW'(off));
               off += wlens[k];
            end
         end
         begin
            int remaining, l;
            remaining = total;
            while (remaining > 0) begin
               l = int'($urandom_range(1, 40));
               if (l > remaining) l = remaining;
               read_burst(l - 1, 3);
               remaining -= l;
            end
         end
      join
      check_eq("sb_drained", 64'(sb.size()), 0);
      check_eq("empty_after_concurrent", 64'(fifo_empty), 1);

      // reset in the middle of an 8-beat write (during beat 5)
      awlen   = 8'd7;
      awvalid = 1'b1;
      @(negedge clk);
      check_eq("aw_before_reset", 64'(awready), 1);
      step();
      awvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wvalid = 1'b1;
         wdata  = 32'h6000 + DW'(i);
         step();
      end
      wdata = 32'h6004;
      #2;
      mon_en = 1'b0;
      resetn = 1'b0;
      #1;
      check_reset_outputs("midreset");
      wvalid = 1'b0;
      sb.delete();
      fill_model = 0;
      @(negedge clk);
      resetn = 1'b1;
      step();
      step();
      check_eq("fill_after_release", 64'(fill_level), 0);
      mon_en = 1'b1;
      write_burst(7, 7, 1, 2'b00, 32'h5000);
      read_burst(7, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
